mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline latch in the 5-stage MIPS pipeline.
- Takes the latched EX/MEM fields and turns dREN/dWEN into a single handshaked data-cache access that waits for dhit.
- Raises a stall to the hazard unit while the access is outstanding.
- Drives the MEM/WB latch (write-back data select, wsel, regWr, halt).

Parameters:
- TIMEOUT_CYCLES, 1023: cycles an access may wait for dhit before mem_err is raised.
- WORD_W, 32: data/address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- advance  in  1  pipeline enable from the hazard unit; MEM/WB loads when high.
- flush  in  1  loads a bubble into MEM/WB on an advance edge.
- dREN_m  in  1  EX/MEM load request.
- dWEN_m  in  1  EX/MEM store request.
- portO_m  in  32  ALU result, used as the memory address.
- dmemstore_m  in  32  store data.
- regWr_m  in  1  register write enable.
- MemToReg_m  in  2  write-back select: 0 ALU, 1 load data, 2 lui value, 3 pc+4.
- luiValue_m  in  32  lui value.
- pcp4_m  in  32  pc+4.
- wsel_m  in  5  destination register (regbits_t).
- halt_m  in  1  halt.
- dhit  in  1  cache access complete.
- dmemload  in  32  load data, valid with dhit.
- dmemREN  out  1  cache read request.
- dmemWEN  out  1  cache write request.
- dmemaddr  out  32  cache address.
- dmemstore  out  32  cache store data.
- mem_stall  out  1  MEM stage busy.
- regWr_wb  out  1  MEM/WB register write enable.
- wsel_wb  out  5  MEM/WB destination register.
- wdat_wb  out  32  MEM/WB write data.
- halt_wb  out  1  MEM/WB halt.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset, checked first every edge: all registered outputs 0, state IDLE, wait counter 0, load buffer 0.
- FSM states:
  - IDLE: no access outstanding.
  - ACCESS: request driven, waiting for dhit.
  - DONE: access finished, waiting for advance.
  - HALTED: absorbing.
- Request outputs:
  - dmemREN = dREN_m & req_phase; dmemWEN = dWEN_m & req_phase.
  - req_phase = (state==IDLE or ACCESS) and (dREN_m|dWEN_m).
  - dmemaddr = portO_m and dmemstore = dmemstore_m, unconditionally.
  - dREN_m and dWEN_m both high is illegal: read takes priority, write is suppressed.
- Latency:
  - The request is driven combinationally in the same cycle the EX/MEM fields present a memory op.
  - If dhit is high in that cycle, the access completes with zero wait.
- mem_stall = req_phase & !dhit. Non-memory ops never stall.
- On the dhit edge: the load buffer captures dmemload on a read. If advance is high, next state is IDLE; otherwise DONE.
- DONE:
  - Requests stay low, so an access is never reissued while upstream is frozen.
  - The stage returns to IDLE on an edge with advance high.
- ACCESS wait counter:
  - Increments each cycle without dhit and clears on leaving ACCESS.
  - When it reaches TIMEOUT_CYCLES, mem_err sets and stays set until reset. The FSM keeps waiting.
- MEM/WB latch, updated only on advance edges:
  - If flush: regWr_wb=0, wsel_wb=0, wdat_wb=0, halt_wb=0.
  - Otherwise capture regWr_m, wsel_m, halt_m, and wdat_wb from MemToReg_m.
  - For MemToReg_m=1, the load data source is dmemload when dhit is high this cycle, else the load buffer.
- Halt:
  - halt_m captured into MEM/WB moves the FSM to HALTED.
  - HALTED: no further requests, mem_stall=0, and MEM/WB holds its values; only reset leaves HALTED.
- Simultaneous advance and flush: flush wins.
- Reset mid-access: requests drop in the reset cycle's next state. No partial write-back.
- wsel_m=0 with regWr_m=1 is passed through unchanged; the register file ignores writes to $0.

Decomposition:
- In cpu_types_pkg:
  - mem_state_t enum {IDLE, ACCESS, DONE, HALTED}.
  - MemToReg encodings as named constants: WB_ALU, WB_LOAD, WB_LUI, WB_PC4.
  - Existing regbits_t and word_t.
- One sub-module, mem_wait_timer: the counter plus sticky mem_err, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Load, lw to addr 0x100, dhit after 3 cycles with dmemload=0xDEADBEEF:
  - mem_stall high exactly 3 cycles, dmemREN high 4 cycles.
  - wdat_wb=0xDEADBEEF, regWr_wb=1 after the advance.
- Store, dWEN_m=1, addr 0x200, data 0x12345678, dhit in the same cycle:
  - dmemWEN high 1 cycle, mem_stall never high, regWr_wb=0.
- Frozen upstream, dhit arrives while advance=0 for 5 cycles:
  - dmemREN low for all 5 cycles (DONE state).
  - On the advance edge, wdat_wb equals the buffered load data.
- Write-back select, MemToReg_m = 2, 3, 0 with luiValue=0xABCD0000, pcp4=0x44, portO=0x7:
  - wdat_wb = 0xABCD0000, 0x44, 0x7 respectively, with no memory requests.
- Timeout, TIMEOUT_CYCLES=8 with dhit withheld:
  - mem_err rises after 8 waiting cycles and stays 1 after a later dhit.
  - Reset clears it.
- Halt and flush:
  - halt_m=1 followed by a lw: halt_wb=1, dmemREN never asserts, mem_stall=0.
  - flush together with advance: MEM/WB outputs all zero.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word types, MEM-stage FSM states, write-back select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   // MEM stage access controller states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      HALTED = 2'd3
   } mem_state_t;

   // MemToReg encodings: source of the write-back word
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_LUI  = 2'd2;
   localparam logic [1:0] WB_PC4  = 2'd3;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a cache access waits for dhit; sets a sticky error at the limit.
// Latency: err_o rises on the edge that ends the TIMEOUT_CYCLES-th waiting cycle.
// Backpressure: none; the counter saturates and the error holds until reset.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wait_i,
   output logic err_o
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Count while waiting (saturating at the limit), clear as soon as the wait ends
   always_comb begin
      cnt_d = '0;
      if (wait_i) begin
         cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
      end
      err_d = err_q | (cnt_d == LIMIT);
   end

   // Counter and sticky error registers, synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: turns EX/MEM load/store into one dhit-handshaked cache access, drives MEM/WB.
// Latency: request is combinational in the cycle the op is presented; zero-wait if dhit same cycle.
// Backpressure: mem_stall while waiting for dhit; DONE holds the result until advance.
module mem_stage_ctrl
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int WORD_W         = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              advance,
   input  logic              flush,
   input  logic              dREN_m,
   input  logic              dWEN_m,
   input  logic [WORD_W-1:0] portO_m,
   input  logic [WORD_W-1:0] dmemstore_m,
   input  logic              regWr_m,
   input  logic [1:0]        MemToReg_m,
   input  logic [WORD_W-1:0] luiValue_m,
   input  logic [WORD_W-1:0] pcp4_m,
   input  regbits_t          wsel_m,
   input  logic              halt_m,
   input  logic              dhit,
   input  logic [WORD_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [WORD_W-1:0] dmemaddr,
   output logic [WORD_W-1:0] dmemstore,
   output logic              mem_stall,
   output logic              regWr_wb,
   output regbits_t          wsel_wb,
   output logic [WORD_W-1:0] wdat_wb,
   output logic              halt_wb,
   output logic              mem_err
);

   mem_state_t        state_q, state_d;
   logic              req_phase;
   logic              rd_req;
   logic              wb_load;
   logic [WORD_W-1:0] ldbuf_q, ldbuf_d;
   logic [WORD_W-1:0] wdat_sel;

   logic              regWr_q, regWr_d;
   regbits_t          wsel_q,  wsel_d;
   logic [WORD_W-1:0] wdat_q,  wdat_d;
   logic              halt_q,  halt_d;

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a halt entering MEM/WB overrides everything; HALTED is absorbing
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ACCESS: begin
            if (req_phase) begin
               if (dhit) begin
                  state_d = advance ? IDLE : DONE;
               end else begin
                  state_d = ACCESS;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DONE: begin
            if (advance) begin
               state_d = IDLE;
            end
         end
         HALTED: state_d = HALTED;
         default: state_d = IDLE;
      endcase
      if (wb_load && !flush && halt_m) begin
         state_d = HALTED;
      end
   end

   // FSM outputs: cache request (read wins over write), stall, MEM/WB load enable
   always_comb begin
      req_phase = ((state_q == IDLE) || (state_q == ACCESS)) && (dREN_m || dWEN_m);
      rd_req    = req_phase && dREN_m;
      dmemREN   = rd_req;
      dmemWEN   = req_phase && dWEN_m && !dREN_m;
      dmemaddr  = portO_m;
      dmemstore = dmemstore_m;
      mem_stall = req_phase && !dhit;
      wb_load   = advance && (state_q != HALTED);
   end

   // Write-back source select; load data bypasses the buffer when dhit is this cycle
   always_comb begin
      wdat_sel = portO_m;
      case (MemToReg_m)
         WB_ALU:  wdat_sel = portO_m;
         WB_LOAD: wdat_sel = dhit ? dmemload : ldbuf_q;
         WB_LUI:  wdat_sel = luiValue_m;
         WB_PC4:  wdat_sel = pcp4_m;
         default: wdat_sel = portO_m;
      endcase
   end

   // Next values for the load buffer and the MEM/WB latch (flush inserts a bubble)
   always_comb begin
      ldbuf_d = (rd_req && dhit) ? dmemload : ldbuf_q;
      regWr_d = regWr_q;
      wsel_d  = wsel_q;
      wdat_d  = wdat_q;
      halt_d  = halt_q;
      if (wb_load) begin
         if (flush) begin
            regWr_d = 1'b0;
            wsel_d  = '0;
            wdat_d  = '0;
            halt_d  = 1'b0;
         end else begin
            regWr_d = regWr_m;
            wsel_d  = wsel_m;
            wdat_d  = wdat_sel;
            halt_d  = halt_m;
         end
      end
   end

   // Load buffer and MEM/WB registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         ldbuf_q <= '0;
         regWr_q <= 1'b0;
         wsel_q  <= '0;
         wdat_q  <= '0;
         halt_q  <= 1'b0;
      end else begin
         ldbuf_q <= ldbuf_d;
         regWr_q <= regWr_d;
         wsel_q  <= wsel_d;
         wdat_q  <= wdat_d;
         halt_q  <= halt_d;
      end
   end

   assign regWr_wb = regWr_q;
   assign wsel_wb  = wsel_q;
   assign wdat_wb  = wdat_q;
   assign halt_wb  = halt_q;

   mem_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk_i (CLK),
      .rst_i (RST),
      .wait_i(mem_stall),
      .err_o (mem_err)
   );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a cycle-level behavioural model and literal spot checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_stage_ctrl;
   import cpu_types_pkg::*;

   localparam int TMO = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        advance = 1'b0, flush = 1'b0;
   logic        dREN_m = 1'b0, dWEN_m = 1'b0;
   logic [31:0] portO_m = '0, dmemstore_m = '0, luiValue_m = '0, pcp4_m = '0;
   logic        regWr_m = 1'b0;
   logic [1:0]  MemToReg_m = '0;
   regbits_t    wsel_m = '0;
   logic        halt_m = 1'b0;
   logic        dhit = 1'b0;
   logic [31:0] dmemload = '0;
   logic        dmemREN, dmemWEN, mem_stall, regWr_wb, halt_wb, mem_err;
   logic [31:0] dmemaddr, dmemstore, wdat_wb;
   regbits_t    wsel_wb;

   int n_cmp = 0, n_bad = 0;
   int n_ren = 0, n_wen = 0, n_stall = 0;
   bit chk_en = 1'b0;

   // model state
   bit          m_done = 0, m_halted = 0, m_err = 0;
   int          m_wait = 0;
   logic [31:0] m_buf = '0, m_wdat = '0;
   logic        m_regWr = 0, m_halt = 0;
   logic [4:0]  m_wsel = '0;

   mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO), .WORD_W(32)) dut (
      .CLK(CLK), .RST(RST), .advance(advance), .flush(flush),
      .dREN_m(dREN_m), .dWEN_m(dWEN_m), .portO_m(portO_m), .dmemstore_m(dmemstore_m),
      .regWr_m(regWr_m), .MemToReg_m(MemToReg_m), .luiValue_m(luiValue_m), .pcp4_m(pcp4_m),
      .wsel_m(wsel_m), .halt_m(halt_m), .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .mem_stall(mem_stall), .regWr_wb(regWr_wb), .wsel_wb(wsel_wb), .wdat_wb(wdat_wb),
      .halt_wb(halt_wb), .mem_err(mem_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic set_nop();
      dREN_m = 0; dWEN_m = 0; portO_m = '0; dmemstore_m = '0; regWr_m = 0;
      MemToReg_m = WB_ALU; luiValue_m = '0; pcp4_m = '0; wsel_m = '0; halt_m = 0;
      dhit = 0; dmemload = '0; flush = 0;
   endtask

   task automatic clr_counts();
      n_ren = 0; n_wen = 0; n_stall = 0;
   endtask

   // Model: an op is requested until it has been satisfied once, unless halted
   always @(negedge CLK) begin
      logic        req;
      logic [31:0] wd;
      req = !m_halted && !m_done && (dREN_m || dWEN_m);
      if (chk_en) begin
         check("dmemREN",   dmemREN,   req && dREN_m);
         check("dmemWEN",   dmemWEN,   req && dWEN_m && !dREN_m);
         check("mem_stall", mem_stall, req && !dhit);
         check("dmemaddr",  dmemaddr,  portO_m);
         check("dmemstore", dmemstore, dmemstore_m);
         check("regWr_wb",  regWr_wb,  m_regWr);
         check("wsel_wb",   wsel_wb,   m_wsel);
         check("wdat_wb",   wdat_wb,   m_wdat);
         check("halt_wb",   halt_wb,   m_halt);
         check("mem_err",   mem_err,   m_err);
      end
      if (dmemREN)   n_ren++;
      if (dmemWEN)   n_wen++;
      if (mem_stall) n_stall++;
      if (RST) begin
         m_done = 0; m_halted = 0; m_err = 0; m_wait = 0; m_buf = '0;
         m_regWr = 0; m_wsel = '0; m_wdat = '0; m_halt = 0;
      end else begin
         case (MemToReg_m)
            2'd0:    wd = portO_m;
            2'd1:    wd = dhit ? dmemload : m_buf;
            2'd2:    wd = luiValue_m;
            default: wd = pcp4_m;
         endcase
         if (req && !dhit) begin
            if (m_wait < TMO) m_wait++;
            if (m_wait == TMO) m_err = 1;
         end else begin
            m_wait = 0;
         end
         if (req && dhit && dREN_m) m_buf = dmemload;
         if (advance) m_done = 0;
         else if (req && dhit) m_done = 1;
         if (advance && !m_halted) begin
            if (flush) begin
               m_regWr = 0; m_wsel = '0; m_wdat = '0; m_halt = 0;
            end else begin
               m_regWr = regWr_m; m_wsel = wsel_m; m_wdat = wd; m_halt = halt_m;
               if (halt_m) m_halted = 1;
            end
         end
      end
   end

   initial begin
      set_nop();
      tick(1);
      chk_en = 1'b1;
      tick(1);
      RST = 0;
      check("reset regWr_wb", regWr_wb, 0);
      check("reset wdat_wb",  wdat_wb,  0);
      check("reset mem_err",  mem_err,  0);
      tick(1);

      // load with 3 wait cycles
      set_nop(); dREN_m = 1; portO_m = 32'h100; MemToReg_m = WB_LOAD; regWr_m = 1; wsel_m = 5;
      advance = 0; clr_counts();
      tick(3);
      dhit = 1; dmemload = 32'hDEADBEEF; advance = 1;
      tick(1);
      check("lw stall cycles", n_stall, 3);
      check("lw REN cycles",   n_ren,   4);
      check("lw wdat_wb",      wdat_wb, 32'hDEADBEEF);
      check("lw regWr_wb",     regWr_wb, 1);
      check("lw wsel_wb",      wsel_wb, 5);
      set_nop(); advance = 0;
      tick(1);

      // zero-wait store
      dWEN_m = 1; portO_m = 32'h200; dmemstore_m = 32'h12345678; dhit = 1; advance = 1;
      clr_counts();
      #1;
      check("sw addr", dmemaddr, 32'h200);
      check("sw data", dmemstore, 32'h12345678);
      tick(1);
      check("sw WEN cycles",   n_wen,   1);
      check("sw stall cycles", n_stall, 0);
      check("sw regWr_wb",     regWr_wb, 0);

      // read and write together: read wins
      set_nop(); dREN_m = 1; dWEN_m = 1; MemToReg_m = WB_LOAD; regWr_m = 1; wsel_m = 2;
      dhit = 1; dmemload = 32'h77; advance = 1;
      #1;
      check("rw REN", dmemREN, 1);
      check("rw WEN", dmemWEN, 0);
      tick(1);
      check("rw wdat_wb", wdat_wb, 32'h77);

      // frozen upstream: dhit while advance low, then 5 frozen cycles
      set_nop(); dREN_m = 1; portO_m = 32'h300; MemToReg_m = WB_LOAD; regWr_m = 1; wsel_m = 7;
      advance = 0; dhit = 1; dmemload = 32'hCAFEF00D;
      tick(1);
      dhit = 0; dmemload = 32'h0BADBAD0; clr_counts();
      tick(5);
      check("frozen REN cycles", n_ren, 0);
      check("frozen stall",      n_stall, 0);
      advance = 1;
      tick(1);
      check("frozen wdat_wb", wdat_wb, 32'hCAFEF00D);

      // write-back select for lui / pc+4 / alu
      set_nop(); luiValue_m = 32'hABCD0000; pcp4_m = 32'h44; portO_m = 32'h7;
      regWr_m = 1; wsel_m = 9; advance = 1; clr_counts();
      MemToReg_m = WB_LUI; tick(1); check("lui wdat_wb", wdat_wb, 32'hABCD0000);
      MemToReg_m = WB_PC4; tick(1); check("pc4 wdat_wb", wdat_wb, 32'h44);
      MemToReg_m = WB_ALU; tick(1); check("alu wdat_wb", wdat_wb, 32'h7);
      check("wbsel requests", n_ren + n_wen, 0);

      // timeout
      set_nop(); dREN_m = 1; portO_m = 32'h400; MemToReg_m = WB_LOAD; regWr_m = 1; wsel_m = 1;
      advance = 0;
      tick(7);
      check("tmo err after 7", mem_err, 0);
      tick(1);
      check("tmo err after 8", mem_err, 1);
      dhit = 1; dmemload = 32'h11; advance = 1;
      tick(1);
      set_nop(); advance = 0;
      tick(2);
      check("tmo err sticky", mem_err, 1);
      RST = 1;
      tick(1);
      RST = 0;
      check("tmo err reset", mem_err, 0);
      tick(1);

      // flush over advance, then halt
      set_nop(); regWr_m = 1; wsel_m = 3; portO_m = 32'h55; advance = 1;
      tick(1);
      check("pre-flush wsel_wb", wsel_wb, 3);
      flush = 1; halt_m = 1;
      tick(1);
      check("flush regWr_wb", regWr_wb, 0);
      check("flush wsel_wb",  wsel_wb,  0);
      check("flush wdat_wb",  wdat_wb,  0);
      check("flush halt_wb",  halt_wb,  0);
      flush = 0; halt_m = 1; regWr_m = 0; wsel_m = 0; portO_m = 32'h99;
      tick(1);
      check("halt halt_wb", halt_wb, 1);
      set_nop(); dREN_m = 1; portO_m = 32'h100; MemToReg_m = WB_LOAD; regWr_m = 1; wsel_m = 4;
      advance = 1; clr_counts();
      tick(4);
      check("halted REN cycles",   n_ren,   0);
      check("halted stall cycles", n_stall, 0);
      check("halted halt_wb",      halt_wb, 1);
      check("halted wdat_wb",      wdat_wb, 32'h99);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
